// File: rtl/jedro_1_test_pkg.sv
// Shared types and constants for the jedro_1 core test sequencer.
// Holds the sequencer state encoding and the register-index width.
package jedro_1_test_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DRAIN,
        ST_CHECK,
        ST_DONE
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jedro_1_test_cnt_if.sv
// Control/status bundle between the sequencer and its phase down-counter.
interface jedro_1_test_cnt_if #(
    parameter int WIDTH = 2
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dec;
    logic             zero;

    modport master (output load, output load_val, output dec, input zero);
    modport slave  (input load, input load_val, input dec, output zero);
endinterface

// File: rtl/jedro_1_test_cnt.sv
// Loadable down counter with zero flag; times both the core-reset hold and
// the post-run pipeline drain.
module jedro_1_test_cnt #(
    parameter int WIDTH = 2
) (
    input logic               i_clk,
    input logic               i_srst,
    jedro_1_test_cnt_if.slave cnt
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_count <= '0;
        end else if (cnt.load) begin
            r_count <= cnt.load_val;
        end else if (cnt.dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign cnt.zero = (r_count == '0);

endmodule

// File: rtl/jedro_1_test_seq.sv
// Core test sequencer: holds the core in reset, lets it run until halt or
// timeout, drains, then compares selected register-file entries.
module jedro_1_test_seq
    import jedro_1_test_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHECKS   = 4,
    parameter int RST_CYCLES   = 3,
    parameter int MAX_CYCLES   = 32,
    parameter int DRAIN_CYCLES = 3,
    localparam int FI_W  = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CYC_W = $clog2(MAX_CYCLES + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             halt_i,
    input  logic [NUM_CHECKS*REG_IDX_W-1:0]  chk_idx_i,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0] chk_exp_i,
    output logic                             core_rstn_o,
    output logic [REG_IDX_W-1:0]             reg_raddr_o,
    input  logic [DATA_WIDTH-1:0]            reg_rdata_i,
    output logic                             done_o,
    output logic                             pass_o,
    output logic                             timeout_o,
    output logic [FI_W-1:0]                  fail_idx_o,
    output logic [DATA_WIDTH-1:0]            fail_val_o,
    output logic [CYC_W-1:0]                 cycles_o
);

    localparam int CNT_MAX = max_int(RST_CYCLES, DRAIN_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // Counter runs load..0 inclusive, so a phase of N cycles loads N-1.
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam seq_state_e       RUN_EXIT   = (DRAIN_CYCLES == 0) ? ST_CHECK : ST_DRAIN;

    seq_state_e            r_state;
    logic                  r_core_rstn;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timeout;
    logic [FI_W-1:0]       r_fail_idx;
    logic [DATA_WIDTH-1:0] r_fail_val;
    logic [CYC_W-1:0]      r_cycles;
    logic [FI_W-1:0]       r_k;

    logic                  w_cnt_load;
    logic [CNT_W-1:0]      w_cnt_val;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;
    logic [REG_IDX_W-1:0]  w_chk_idx;
    logic [DATA_WIDTH-1:0] w_chk_exp;
    logic [CYC_W-1:0]      w_cyc_next;
    logic                  w_cyc_limit;
    logic                  w_match;
    logic                  w_last;

    jedro_1_test_cnt_if #(.WIDTH(CNT_W)) u_cnt_bus ();

    assign u_cnt_bus.load     = w_cnt_load;
    assign u_cnt_bus.load_val = w_cnt_val;
    assign u_cnt_bus.dec      = w_cnt_dec;
    assign w_cnt_zero         = u_cnt_bus.zero;

    jedro_1_test_cnt #(.WIDTH(CNT_W)) u_cnt (
        .i_clk  (clk_i),
        .i_srst (rst_i),
        .cnt    (u_cnt_bus)
    );

    assign w_chk_idx   = chk_idx_i[int'(r_k)*REG_IDX_W +: REG_IDX_W];
    assign w_chk_exp   = chk_exp_i[int'(r_k)*DATA_WIDTH +: DATA_WIDTH];
    assign w_match     = (reg_rdata_i == w_chk_exp);
    assign w_last      = (r_k == FI_W'(NUM_CHECKS - 1));
    assign w_cyc_next  = (r_cycles == CYC_W'(MAX_CYCLES)) ? r_cycles : r_cycles + 1'b1;
    assign w_cyc_limit = (w_cyc_next == CYC_W'(MAX_CYCLES));

    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = RST_LOAD;
                end
            end
            ST_RESET, ST_DRAIN: w_cnt_dec = 1'b1;
            ST_RUN: begin
                if (halt_i || w_cyc_limit) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = DRAIN_LOAD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_core_rstn <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_idx  <= '0;
            r_fail_val  <= '0;
            r_cycles    <= '0;
            r_k         <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        r_state     <= ST_RESET;
                        r_core_rstn <= 1'b0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_fail_idx  <= '0;
                        r_fail_val  <= '0;
                        r_cycles    <= '0;
                        r_k         <= '0;
                    end
                end
                ST_RESET: begin
                    if (w_cnt_zero) begin
                        r_state     <= ST_RUN;
                        r_core_rstn <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cycles <= w_cyc_next;
                    // Halt takes priority when it coincides with the limit.
                    if (halt_i || w_cyc_limit) begin
                        r_timeout <= !halt_i;
                        r_state   <= RUN_EXIT;
                        r_k       <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!w_match) begin
                        r_fail_idx <= r_k;
                        r_fail_val <= reg_rdata_i;
                        r_pass     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end else if (w_last) begin
                        r_pass  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign reg_raddr_o = (r_state == ST_CHECK) ? w_chk_idx : '0;
    assign core_rstn_o = r_core_rstn;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign timeout_o   = r_timeout;
    assign fail_idx_o  = r_fail_idx;
    assign fail_val_o  = r_fail_val;
    assign cycles_o    = r_cycles;

endmodule

// File: tb/tb_jedro_1_test_seq.sv
// Directed bench: two sequencer instances (two checks with drain, one check
// without drain) share stimulus against a modelled register file.
module tb_jedro_1_test_seq;

    localparam int MAXC = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, start_i, halt_i;
    logic [31:0] regs [32];

    logic [9:0]  chk_idx0;
    logic [63:0] chk_exp0;
    logic        rstn0, done0, pass0, to0;
    logic [4:0]  raddr0;
    logic [31:0] rdata0, fval0;
    logic [0:0]  fidx0;
    logic [5:0]  cycles0;

    logic [4:0]  chk_idx1;
    logic [31:0] chk_exp1;
    logic        rstn1, done1, pass1, to1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1, fval1;
    logic [0:0]  fidx1;
    logic [5:0]  cycles1;

    int n_cmp = 0;
    int n_err = 0;

    assign rdata0 = regs[raddr0];
    assign rdata1 = regs[raddr1];

    jedro_1_test_seq #(
        .DATA_WIDTH(32), .NUM_CHECKS(2), .RST_CYCLES(3), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(3)
    ) u_dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
        .chk_idx_i(chk_idx0), .chk_exp_i(chk_exp0), .core_rstn_o(rstn0),
        .reg_raddr_o(raddr0), .reg_rdata_i(rdata0), .done_o(done0), .pass_o(pass0),
        .timeout_o(to0), .fail_idx_o(fidx0), .fail_val_o(fval0), .cycles_o(cycles0)
    );

    jedro_1_test_seq #(
        .DATA_WIDTH(32), .NUM_CHECKS(1), .RST_CYCLES(3), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(0)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
        .chk_idx_i(chk_idx1), .chk_exp_i(chk_exp1), .core_rstn_o(rstn1),
        .reg_raddr_o(raddr1), .reg_rdata_i(rdata1), .done_o(done1), .pass_o(pass1),
        .timeout_o(to1), .fail_idx_o(fidx1), .fail_val_o(fval1), .cycles_o(cycles1)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start pulse, then core reset must stay low for exactly 3 cycles.
    task automatic start_seq();
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        check("rstn_t+1", rstn0, 0);
        check("done_cleared", done0, 0);
        check("cycles_cleared", cycles0, 0);
        step(2);
        check("rstn_t+3", rstn0, 0);
        step(1);
        check("rstn_t+4", rstn0, 1);
        check("rstn1_t+4", rstn1, 1);
    endtask

    task automatic run_to(input int halt_at);
        if (halt_at > 0) begin
            step(halt_at - 1);
            check("cycles_before_halt", cycles0, halt_at - 1);
            halt_i = 1'b1;
            step(1);
            halt_i = 1'b0;
        end else begin
            step(MAXC - 1);
            check("cycles_limit_minus1", cycles0, MAXC - 1);
            check("timeout_early", to0, 0);
            step(1);
        end
        check("raddr_outside_check", raddr0, 0);
    endtask

    task automatic finish_checks(input logic exp_pass, input logic [31:0] exp_fidx,
                                 input logic [31:0] exp_fval, input logic exp_to,
                                 input logic [31:0] exp_cyc);
        check("cycles", cycles0, exp_cyc);
        check("timeout", to0, exp_to);
        check("cycles1", cycles1, exp_cyc);
        check("timeout1", to1, exp_to);
        step(1);
        check("done1", done1, 1);
        check("pass1", pass1, 1);
        check("done_during_drain", done0, 0);
        step(2);
        check("raddr_k0", raddr0, 6);
        step(1);
        check("raddr_k1", raddr0, 7);
        check("done_at_k1", done0, 0);
        step(1);
        check("done", done0, 1);
        check("pass", pass0, exp_pass);
        check("fail_idx", fidx0, exp_fidx);
        check("fail_val", fval0, exp_fval);
        check("raddr_in_done", raddr0, 0);
        check("rstn_in_done", rstn0, 1);
        check("timeout_held", to0, exp_to);
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        halt_i  = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3 + 100);
        regs[6]  = 32'd1055;
        regs[7]  = 32'd5;
        chk_idx0 = {5'd7, 5'd6};
        chk_exp0 = {32'd5, 32'd1055};
        chk_idx1 = 5'd6;
        chk_exp1 = 32'd1055;

        step(3);
        check("rst_rstn", rstn0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_timeout", to0, 0);
        check("rst_fail_idx", fidx0, 0);
        check("rst_fail_val", fval0, 0);
        check("rst_cycles", cycles0, 0);
        rst_i = 1'b0;
        step(2);
        check("idle_rstn", rstn0, 0);
        check("idle_raddr", raddr0, 0);

        // Halt on RUN cycle 10, all checks match.
        start_seq();
        run_to(10);
        finish_checks(1'b1, 0, 0, 1'b0, 10);

        // Second check mismatches (reg7 reads 4), rerun from DONE.
        regs[7] = 32'd4;
        start_seq();
        run_to(5);
        finish_checks(1'b0, 1, 4, 1'b0, 5);

        // No halt: timeout at the cycle limit; pass is still evaluated.
        regs[7] = 32'd5;
        start_seq();
        run_to(0);
        finish_checks(1'b1, 0, 0, 1'b1, 32);

        // Halt exactly on the limit cycle: halt wins.
        start_seq();
        run_to(32);
        finish_checks(1'b1, 0, 0, 1'b0, 32);

        // Reset while in DONE clears results.
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        check("rst_done_from_done", done0, 0);
        check("rst_pass_from_done", pass0, 0);
        check("rst_rstn_from_done", rstn0, 0);

        // start ignored in RUN, then reset mid-RUN.
        start_seq();
        step(1);
        check("run_cycles_1", cycles0, 1);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        check("start_ignored_cycles", cycles0, 2);
        check("start_ignored_rstn", rstn0, 1);
        step(2);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        check("midrun_rst_rstn", rstn0, 0);
        check("midrun_rst_cycles", cycles0, 0);
        check("midrun_rst_done", done0, 0);
        check("midrun_rst_timeout", to0, 0);
        check("midrun_rst_rstn1", rstn1, 0);
        step(2);
        check("midrun_idle_rstn", rstn0, 0);
        check("midrun_idle_cycles", cycles0, 0);

        // Clean rerun gives the same results as the first run.
        start_seq();
        run_to(10);
        finish_checks(1'b1, 0, 0, 1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jedro_1_test_seq.md
JEDRO_1_TEST_SEQ -- requirements
Module: jedro_1_test_seq

Interface
REQ-001 Parameter DATA_WIDTH, 32, register data width.
REQ-002 Parameter NUM_CHECKS, 4, number of (register index, expected value) checks; range 1..32.
REQ-003 Parameter RST_CYCLES, 3, core reset hold length in cycles; minimum 1.
REQ-004 Parameter MAX_CYCLES, 32, RUN-phase cycle limit before timeout; minimum 1.
REQ-005 Parameter DRAIN_CYCLES, 3, pipeline drain cycles after RUN ends; 0 allowed.
REQ-006 clk_i  in  1  sole clock, all state updates on its rising edge.
REQ-007 rst_i  in  1  synchronous, active-high reset.
REQ-008 start_i  in  1  single-cycle start request.
REQ-009 halt_i  in  1  core halt indication (decoder illegal-instruction flag).
REQ-010 chk_idx_i  in  NUM_CHECKS*5  packed register indexes; check k at bits [5k+4:5k].
REQ-011 chk_exp_i  in  NUM_CHECKS*DATA_WIDTH  packed expected values; check k at slice k.
REQ-012 core_rstn_o  out  1  active-low reset driven to the core.
REQ-013 reg_raddr_o  out  5  register-file debug read address.
REQ-014 reg_rdata_i  in  DATA_WIDTH  combinational read data for reg_raddr_o, same cycle.
REQ-015 done_o, pass_o, timeout_o  out  1 each  result flags.
REQ-016 fail_idx_o  out  max(1,$clog2(NUM_CHECKS))  index of first failing check.
REQ-017 fail_val_o  out  DATA_WIDTH  value read by the first failing check.
REQ-018 cycles_o  out  $clog2(MAX_CYCLES+1)  RUN cycles elapsed.

Function
REQ-019 FSM states: IDLE, RESET, RUN, DRAIN, CHECK, DONE; all outputs registered, except reg_raddr_o, which is combinational from state and check index.
REQ-020 IDLE: core_rstn_o=0; start_i -> RESET next cycle; result flags, fail_* and cycles_o cleared on that transition.
REQ-021 RESET: core_rstn_o=0 for exactly RST_CYCLES cycles; then RUN, core_rstn_o=1 from first RUN cycle onward, including DRAIN, CHECK and DONE.
REQ-022 RUN: cycles_o increments each cycle it stays in RUN; it saturates at MAX_CYCLES.
REQ-023 RUN exit: halt_i=1 -> DRAIN with timeout_o=0; cycles_o reaching MAX_CYCLES with halt_i=0 -> DRAIN with timeout_o=1.
REQ-024 RUN exit, both events in same cycle: halt wins, timeout_o=0.
REQ-025 DRAIN: lasts DRAIN_CYCLES cycles (0 -> direct to CHECK); halt_i ignored.
REQ-026 CHECK: one check per cycle, k=0..NUM_CHECKS-1; reg_raddr_o=chk_idx[k]; compare reg_rdata_i with chk_exp[k].
REQ-027 CHECK, first mismatch: capture fail_idx_o=k and fail_val_o=reg_rdata_i, set pass_o=0, go to DONE; remaining checks skipped.
REQ-028 CHECK, all checks match: pass_o=1 and go to DONE after check NUM_CHECKS-1.
REQ-029 pass_o reflects comparisons only; timeout_o is independent.
REQ-030 DONE: done_o=1; all results held; start_i -> RESET (rerun) with results cleared.
REQ-031 start_i is ignored in RESET, RUN, DRAIN and CHECK.
REQ-032 reg_raddr_o=0 outside CHECK.

Reset
REQ-033 rst_i=1 at any edge, any state -> IDLE next cycle.
REQ-034 Reset values: core_rstn_o=0, done_o=0, pass_o=0, timeout_o=0, fail_idx_o=0, fail_val_o=0, cycles_o=0, all counters 0.

Structure
REQ-035 Package jedro_1_test_pkg holds the state enum and the register-index width constant (5).
REQ-036 Sub-module jedro_1_test_cnt: parametrised-width down counter with load and zero flag, shared by RESET and DRAIN phases.

Verification
REQ-037 NUM_CHECKS=1, idx 6 exp 1055, halt_i at RUN cycle 10, reg6=1055 -> done_o=1, pass_o=1, timeout_o=0, cycles_o=10.
REQ-038 Checks {6:1055, 7:5}, reg7 reads 4 -> pass_o=0, fail_idx_o=1, fail_val_o=4; CHECK lasts 2 cycles.
REQ-039 halt_i never asserted, MAX_CYCLES=32 -> timeout_o=1, cycles_o=32; halt_i on cycle 32 instead -> timeout_o=0.
REQ-040 start_i at cycle t -> core_rstn_o low through t+RST_CYCLES, high at t+RST_CYCLES+1.
REQ-041 rst_i asserted mid-RUN -> IDLE, core_rstn_o=0, all results 0; start_i from DONE -> clean rerun with identical results.
